// File: rtl/pin_pkg.sv
// pin_pkg: shared FSM states and serial line levels for the pin emit/capture pair
package pin_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;
endpackage

// File: rtl/pin_fifo.sv
// pin_fifo: synchronous word FIFO with occupancy count
module pin_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk600,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] lvl
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always_ff @(posedge clk600 or negedge rst_n)
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            lvl <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            lvl <= lvl + LW'(push) - LW'(pop);
        end
    always_ff @(posedge clk600)
        if (push) mem[wp] <= din;
    assign dout  = mem[rp];
    assign full  = lvl == LW'(DEPTH);
    assign empty = lvl == '0;
endmodule

// File: rtl/pin_emit.sv
// pin_emit: FIFO-buffered parallel-to-serial framed line transmitter
module pin_emit
    import pin_pkg::*;
#(
    parameter int W = 8,
    parameter int DEPTH = 4,
    parameter int BIT_CYCLES = 4,
    parameter int GAP_BITS = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk600,
    input  logic                     rst_n,
    input  logic [W-1:0]             data_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic                     pin_out,
    output logic                     str,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   lvl
);
    localparam int BCW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int BW  = $clog2(W);
    localparam int GW  = GAP_BITS > 1 ? $clog2(GAP_BITS) : 1;
    state_t         state, state_nx;
    logic [BCW-1:0] bc, bc_nx;
    logic [BW-1:0]  bi, bi_nx;
    logic [GW-1:0]  gi, gi_nx;
    logic [W-1:0]   sh, sh_nx, head;
    logic           pin_nx, str_nx, busy_nx;
    logic           full, empty, push, launch;
    logic           bit_end, gap_last, frame_done, shift_en, last_bit, nxt_bit;
    pin_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk600(clk600),
        .rst_n(rst_n),
        .push(push),
        .din(data_in),
        .pop(launch),
        .dout(head),
        .full(full),
        .empty(empty),
        .lvl(lvl)
    );
    assign ready_out  = !full;
    assign push       = valid_in && ready_out;
    assign bit_end    = bc == BCW'(BIT_CYCLES - 1);
    assign gap_last   = (GAP_BITS == 0) || (gi == GW'(GAP_BITS - 1));
    assign frame_done = bit_end && (state == GAP ? gap_last : (state == STOP && GAP_BITS == 0));
    assign launch     = (state == IDLE || frame_done) && !empty;
    assign shift_en   = bit_end && (state == START || state == DATA);
    assign last_bit   = state == DATA && bi == BW'(W - 1);
    assign nxt_bit    = MSB_FIRST ? sh[W-1] : sh[0];
    always_ff @(posedge clk600 or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            bc      <= '0;
            bi      <= '0;
            gi      <= '0;
            sh      <= '0;
            pin_out <= LINE_IDLE;
            str     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            bc      <= bc_nx;
            bi      <= bi_nx;
            gi      <= gi_nx;
            sh      <= sh_nx;
            pin_out <= pin_nx;
            str     <= str_nx;
            busy    <= busy_nx;
        end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = launch ? START : IDLE;
            START:   state_nx = bit_end ? DATA : START;
            DATA:    state_nx = (bit_end && last_bit) ? STOP : DATA;
            default: state_nx = frame_done ? (launch ? START : IDLE) : (state == STOP && bit_end) ? GAP : state;
        endcase
    end
    always_comb begin
        bc_nx   = (state == IDLE || bit_end) ? '0 : bc + 1'b1;
        bi_nx   = state != DATA ? '0 : bit_end ? bi + 1'b1 : bi;
        gi_nx   = state != GAP ? '0 : bit_end ? gi + 1'b1 : gi;
        sh_nx   = launch ? head : shift_en ? (MSB_FIRST ? sh << 1 : sh >> 1) : sh;
        pin_nx  = launch ? LINE_START : shift_en ? (last_bit ? LINE_STOP : nxt_bit) : (state == IDLE || frame_done) ? LINE_IDLE : pin_out;
        str_nx  = launch;
        busy_nx = launch || (busy && state != IDLE && !frame_done);
    end
endmodule

// File: doc/pin_emit.md
Name: pin_emit

Overview:
- Parallel-to-serial line transmitter. It is the transmit-side counterpart to the pin capture deserializer.
- It runs entirely in the clk600 domain, which the PLL provides.
- Parallel words come in on a valid/ready handshake. They are buffered in a small FIFO, framed, and driven out bit-serially on pin_out at BIT_CYCLES clk600 cycles per bit, with a frame strobe for the receiver and the bench.

Parameters:
- W, 8: data word width in bits (>=2).
- DEPTH, 4: FIFO depth in words (power of 2, >=2).
- BIT_CYCLES, 4: clk600 cycles per serial bit (>=1).
- GAP_BITS, 1: idle bit times inserted after each stop bit (0 allowed).
- MSB_FIRST, 1: 1 sends data MSB first, 0 sends LSB first.

Ports:
- clk600  in  1  sole clock. All state is updated on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  W  word to transmit.
- valid_in  in  1  data_in is valid.
- ready_out  out  1  FIFO can accept a word.
- pin_out  out  1  serial line. Idles at 0.
- str  out  1  one-cycle pulse on the first clk600 cycle of each start bit.
- busy  out  1  a frame or its gap is in progress.
- lvl  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface rule: one clock (clk600); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous):
  - pin_out=0, str=0, busy=0, lvl=0, so ready_out=1.
  - FIFO pointers cleared and FSM forced to IDLE. Any frame in progress is dropped immediately; there is no stop-bit completion.
  - Deassertion is sampled at the next clk600 edge.
- Handshake:
  - A word is accepted on an edge where valid_in && ready_out.
  - ready_out = (lvl != DEPTH), combinational from registered count.
  - data_in must be held while valid_in=1 and ready_out=0.
  - Push while full is impossible by construction.
- FIFO:
  - Simultaneous push and pop with 0<lvl<DEPTH leaves lvl unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop on empty never occurs; the FSM pops only when lvl!=0.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - A bit-cycle counter bc runs 0..BIT_CYCLES-1. A bit index bi runs 0..W-1.
  - IDLE: pin_out=0. If lvl!=0 at an edge: pop the head into the shift register, bc=0, go to START, pin_out<=1, str<=1.
  - START: str<=0 after its first cycle. When bc reaches BIT_CYCLES-1: go to DATA, drive the first data bit, bi=0.
  - DATA: on each bit-time end, shift and drive the next bit. After bit W-1's bit time: go to STOP, pin_out<=0.
  - STOP: lasts one bit time. Then go to GAP if GAP_BITS>0, else back-to-back.
  - GAP: pin_out=0 for GAP_BITS bit times.
  - Back-to-back: at the end of STOP (or GAP), if lvl!=0, pop and enter START on that same edge with no idle cycle; otherwise go to IDLE.
- Latency: a word accepted into an empty FIFO while IDLE at edge N gives pin_out=1 and str=1 from edge N+1.
- Frame length: (W+2)*BIT_CYCLES cycles. busy is high for (W+2+GAP_BITS)*BIT_CYCLES cycles per frame and is registered, set together with the START entry.
- All outputs except ready_out and lvl are registered; there is no combinational path from the inputs to pin_out.
- A push arriving during a pop edge is counted correctly for the lvl-driven decision on the next edge.

Decomposition:
- Package pin_pkg:
  - state enum (IDLE, START, DATA, STOP, GAP);
  - line-level constants LINE_IDLE=0, LINE_START=1, LINE_STOP=0.
- The pin capture receiver imports the same constants.
- One sub-module, pin_fifo (synchronous FIFO, parameters W and DEPTH, push/pop/full/empty/lvl, same clk600/rst_n).
- The FSM, counters and shift register stay in pin_emit.

Test Plan:
- Single word, W=8, BIT_CYCLES=4, GAP_BITS=1, MSB_FIRST=1.
  - Stimulus: push 0xA5 at edge N.
  - Required: str high only at cycle N+1; pin_out 1 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 0 for 4 stop cycles; busy high 44 cycles; lvl 1→0 at N+1.
- LSB-first: same as above with MSB_FIRST=0, push 0x01 → first data bit 1, then seven 0 bits.
- Back-to-back, GAP_BITS=0.
  - Stimulus: push 0xFF, 0x00, 0x3C in consecutive cycles.
  - Required: three contiguous 40-cycle frames; str pulses exactly 40 cycles apart; no idle cycle between frames; busy continuously high 120 cycles.
- Full/backpressure, DEPTH=4.
  - Stimulus: hold valid_in for 6 words while the first frame is sending.
  - Required: ready_out=0 while lvl=4; words 5–6 accepted only after pops; all 6 words transmitted in order, none lost or duplicated.
- Reset mid-frame.
  - Stimulus: assert rst_n=0 during DATA bit 3 of 0xA5 while lvl=2.
  - Required: pin_out=0, busy=0, lvl=0, ready_out=1 immediately (before the next edge); after release, line idle at 0 until a new push.
- Simultaneous push/pop.
  - Stimulus: lvl=2 and a push on the same edge the FSM pops.
  - Required: lvl stays 2; the word order is preserved in the serial stream.
